// File: rtl/ctrl_seq_decoder.sv
// ---------------------------------------------------------------------------
// ctrl_seq_decoder
//   Registered, table-driven control decoder. An opcode accepted on the input
//   handshake is looked up in a writable decode table. The entry's control
//   word is then issued on the output handshake for len+1 consecutive beats,
//   and each beat carries its micro-step index.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready opcode handshake (in_ready is combinational)
//   in_opc            opcode to decode
//   out_valid/ready   control-word handshake
//   out_cw            control word of the current op
//   out_step          0-based micro-step index
//   out_last          high on the final beat of an op
//   flush             synchronous abort of the current op
//   cfg_we/addr/data  decode-table write port, data = {legal, len, cw}
//   err_illegal       one-cycle pulse after an illegal opcode is consumed
// ---------------------------------------------------------------------------
module ctrl_seq_decoder #(
  parameter int OPC_W = 7,
  parameter int CW_W  = 26,
  parameter int LEN_W = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [OPC_W-1:0]          in_opc,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CW_W-1:0]           out_cw,
  output logic [LEN_W-1:0]          out_step,
  output logic                      out_last,
  input  logic                      flush,
  input  logic                      cfg_we,
  input  logic [OPC_W-1:0]          cfg_addr,
  input  logic [1+LEN_W+CW_W-1:0]   cfg_data,
  output logic                      err_illegal
);

  localparam int ENT_W = 1 + LEN_W + CW_W;
  localparam int DEPTH = 1 << OPC_W;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ISSUE = 1'b1;

  // Decode table. The whole table has to clear on reset, so it is kept in
  // flops rather than in a RAM.
  logic [ENT_W-1:0] table_reg [DEPTH];

  logic [0:0]       state_reg, state_next;
  logic [CW_W-1:0]  cw_reg, cw_next;
  logic [LEN_W-1:0] len_reg, len_next;
  logic [LEN_W-1:0] step_reg, step_next;
  logic             last_reg, last_next;
  logic             err_reg, err_next;

  logic [ENT_W-1:0] entry;
  logic             ent_legal;
  logic [LEN_W-1:0] ent_len;
  logic [CW_W-1:0]  ent_cw;
  logic [LEN_W-1:0] step_inc;
  logic             accept;

  // Lookup reads the table as it stood before this edge, so a write to the
  // same address in the same cycle is only seen by later lookups.
  assign entry     = table_reg[in_opc];
  assign ent_legal = entry[ENT_W-1];
  assign ent_len   = entry[CW_W +: LEN_W];
  assign ent_cw    = entry[CW_W-1:0];

  // Ready on the last beat's handshake as well, so ops run back to back.
  assign in_ready = !flush && ((state_reg == IDLE) ||
                               ((state_reg == ISSUE) && out_ready && last_reg));
  assign accept   = in_valid && in_ready;
  assign step_inc = step_reg + LEN_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        table_reg[i] <= '0;
      end
    end else if (cfg_we) begin
      table_reg[cfg_addr] <= cfg_data;
    end
  end

  always_comb begin
    state_next = state_reg;
    cw_next    = cw_reg;
    len_next   = len_reg;
    step_next  = step_reg;
    last_next  = last_reg;
    err_next   = 1'b0;

    if (flush) begin
      state_next = IDLE;
      step_next  = '0;
      last_next  = 1'b0;
    end else begin
      err_next = accept && !ent_legal;
      if (accept && ent_legal) begin
        // The entry is latched here; later table writes cannot disturb it.
        state_next = ISSUE;
        cw_next    = ent_cw;
        len_next   = ent_len;
        step_next  = '0;
        last_next  = (ent_len == '0);
      end else if ((state_reg == ISSUE) && out_ready) begin
        if (last_reg) begin
          state_next = IDLE;
          step_next  = '0;
          last_next  = 1'b0;
        end else begin
          step_next  = step_inc;
          last_next  = (step_inc == len_reg);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cw_reg    <= '0;
      len_reg   <= '0;
      step_reg  <= '0;
      last_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cw_reg    <= cw_next;
      len_reg   <= len_next;
      step_reg  <= step_next;
      last_reg  <= last_next;
      err_reg   <= err_next;
    end
  end

  assign out_valid   = (state_reg == ISSUE);
  assign out_cw      = cw_reg;
  assign out_step    = step_reg;
  assign out_last    = last_reg;
  assign err_illegal = err_reg;

endmodule

// File: tb/tb_ctrl_seq_decoder.sv
// ---------------------------------------------------------------------------
// tb_ctrl_seq_decoder
//   Self-checking bench for ctrl_seq_decoder. A transaction-level reference
//   model keeps a copy of the decode table and a queue of the beats that are
//   still owed. Each accepted legal op pushes len+1 beats, and each output
//   handshake pops one. Directed scenarios are followed by a randomized run.
// ---------------------------------------------------------------------------
module tb_ctrl_seq_decoder;

  localparam int OPC_W = 7;
  localparam int CW_W  = 26;
  localparam int LEN_W = 2;
  localparam int ENT_W = 1 + LEN_W + CW_W;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [OPC_W-1:0] in_opc;
  logic             out_valid;
  logic             out_ready;
  logic [CW_W-1:0]  out_cw;
  logic [LEN_W-1:0] out_step;
  logic             out_last;
  logic             flush;
  logic             cfg_we;
  logic [OPC_W-1:0] cfg_addr;
  logic [ENT_W-1:0] cfg_data;
  logic             err_illegal;

  ctrl_seq_decoder #(.OPC_W(OPC_W), .CW_W(CW_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_opc(in_opc),
    .out_valid(out_valid), .out_ready(out_ready), .out_cw(out_cw),
    .out_step(out_step), .out_last(out_last),
    .flush(flush),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .err_illegal(err_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [CW_W-1:0]  cw;
    logic [LEN_W-1:0] step;
    logic             last;
  } beat_t;

  logic [ENT_W-1:0] mtab [1 << OPC_W];
  beat_t            exp_q [$];
  logic             exp_err;
  int               n_checks;
  int               n_fail;
  int               valid_beats;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < (1 << OPC_W); i++) mtab[i] = '0;
    exp_q.delete();
    exp_err = 1'b0;
  endtask

  // One clock cycle: inputs are already driven. in_ready is checked mid-cycle,
  // the model advances by the handshakes, and the outputs are checked after the edge.
  task automatic step();
    logic             exp_rdy;
    logic             acc;
    logic [ENT_W-1:0] e;
    int               len;
    @(negedge clk);
    exp_rdy = !flush && ((exp_q.size() == 0) || (out_ready && exp_q[0].last));
    check_eq("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    acc     = in_valid && exp_rdy;
    exp_err = 1'b0;
    if (flush) begin
      exp_q.delete();
    end else begin
      if ((exp_q.size() > 0) && out_ready) void'(exp_q.pop_front());
      if (acc) begin
        e   = mtab[in_opc];
        len = int'(e[CW_W +: LEN_W]);
        $display("txn t=%0t opc=0x%02h legal=%0d len=%0d cw=0x%07h",
                 $time, in_opc, e[ENT_W-1], len, e[CW_W-1:0]);
        if (e[ENT_W-1]) begin
          for (int s = 0; s <= len; s++)
            exp_q.push_back('{cw: e[CW_W-1:0], step: LEN_W'(s), last: (s == len)});
        end else begin
          exp_err = 1'b1;
        end
      end
    end
    if (cfg_we) mtab[cfg_addr] = cfg_data;
    @(posedge clk);
    #1;
    check_eq("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() > 0});
    if (exp_q.size() > 0) begin
      valid_beats++;
      check_eq("out_cw",   {6'd0, out_cw},    {6'd0, exp_q[0].cw});
      check_eq("out_step", {30'd0, out_step}, {30'd0, exp_q[0].step});
      check_eq("out_last", {31'd0, out_last}, {31'd0, exp_q[0].last});
    end
    check_eq("err_illegal", {31'd0, err_illegal}, {31'd0, exp_err});
  endtask

  task automatic cfg_write(input logic [OPC_W-1:0] a, input logic [ENT_W-1:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic send(input logic [OPC_W-1:0] opc);
    in_valid = 1'b1; in_opc = opc;
    step();
    in_valid = 1'b0;
  endtask

  int   mb_steps [6] = '{0, 1, 1, 1, 2, 3};
  logic mb_ready [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    n_checks = 0; n_fail = 0; valid_beats = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_opc = '0; out_ready = 1'b0; flush = 1'b0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    model_reset();

    #1;
    check_eq("rst_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_cw",    {6'd0, out_cw},     32'd0);
    check_eq("rst_step",  {30'd0, out_step},  32'd0);
    check_eq("rst_last",  {31'd0, out_last},  32'd0);
    check_eq("rst_err",   {31'd0, err_illegal}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single-beat op.
    cfg_write(7'h12, {1'b1, 2'd0, 26'h2AAAAAA});
    out_ready = 1'b1;
    send(7'h12);
    check_eq("sb_cw",   {6'd0, out_cw}, 32'h2AAAAAA);
    check_eq("sb_last", {31'd0, out_last}, 32'd1);
    step();
    check_eq("sb_idle", {31'd0, out_valid}, 32'd0);

    // Multi-beat op with stalls on the output.
    cfg_write(7'h40, {1'b1, 2'd3, 26'h0000F0F});
    send(7'h40);
    for (int i = 0; i < 6; i++) begin
      check_eq("mb_step", {30'd0, out_step}, mb_steps[i]);
      check_eq("mb_cw",   {6'd0, out_cw}, 32'h0000F0F);
      out_ready = mb_ready[i];
      step();
    end
    check_eq("mb_done", {31'd0, out_valid}, 32'd0);

    // Back-to-back ops with no bubble.
    out_ready = 1'b1;
    valid_beats = 0;
    in_valid = 1'b1; in_opc = 7'h12;
    step();
    in_opc = 7'h40;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check_eq("b2b_beats", valid_beats, 32'd5);

    // A write and a lookup of the same address in one cycle use the old entry.
    cfg_we = 1'b1; cfg_addr = 7'h12; cfg_data = {1'b1, 2'd0, 26'h1};
    send(7'h12);
    cfg_we = 1'b0;
    check_eq("col_old", {6'd0, out_cw}, 32'h2AAAAAA);
    send(7'h12);
    check_eq("col_new", {6'd0, out_cw}, 32'h1);
    step();

    // Flush at step 1 with an opcode pending.
    send(7'h40);
    step();
    check_eq("fl_step1", {30'd0, out_step}, 32'd1);
    flush = 1'b1; in_valid = 1'b1; in_opc = 7'h12;
    step();
    check_eq("fl_valid", {31'd0, out_valid}, 32'd0);
    flush = 1'b0; in_opc = 7'h40;
    step();
    in_valid = 1'b0;
    check_eq("fl_restart", {30'd0, out_step}, 32'd0);
    for (int i = 0; i < 4; i++) step();

    // Asynchronous reset in the middle of an op.
    send(7'h40);
    out_ready = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_valid", {31'd0, out_valid}, 32'd0);
    check_eq("arst_last",  {31'd0, out_last}, 32'd0);
    check_eq("arst_step",  {30'd0, out_step}, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(7'h05);
    check_eq("ill_pulse", {31'd0, err_illegal}, 32'd1);
    step();
    send(7'h12);   // table was cleared, so this is illegal too
    step();

    // Randomized traffic on a small opcode range so entries are reused.
    for (int i = 0; i < 8; i++)
      cfg_write(OPC_W'(i), {1'($urandom_range(0, 3) != 0), 2'($urandom), 26'($urandom)});
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      in_opc    = OPC_W'($urandom_range(0, 7));
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 39) == 0);
      cfg_we    = ($urandom_range(0, 9) < 2);
      cfg_addr  = OPC_W'($urandom_range(0, 7));
      cfg_data  = {1'($urandom_range(0, 3) != 0), 2'($urandom), 26'($urandom)};
      step();
    end
    in_valid = 1'b0; flush = 1'b0; cfg_we = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check_eq("drain", {31'd0, out_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ctrl_seq_decoder.md
Name: ctrl_seq_decoder

Overview:
Programmable, registered successor to the combinational 7-in/26-out control decoder. An opcode accepted on a valid/ready input is looked up in a writable decode table. The block then issues the table's control word on a valid/ready output for 1..2^LEN_W consecutive micro-steps. It sits between instruction fetch and datapath control, and replaces hardwired decode with a table loaded at boot or runtime.

Parameters:
- OPC_W, 7, opcode width; table depth is 2^OPC_W entries.
- CW_W, 26, control-word width.
- LEN_W, 2, step-count field width; an op lasts len+1 beats (1..2^LEN_W).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  opcode valid.
- in_ready  out  1  opcode accepted when in_valid && in_ready.
- in_opc  in  OPC_W  opcode.
- out_valid  out  1  control word valid.
- out_ready  in  1  consumer accepts beat.
- out_cw  out  CW_W  control word.
- out_step  out  LEN_W  current micro-step index, 0-based.
- out_last  out  1  high on the final beat of an op.
- flush  in  1  synchronous abort.
- cfg_we  in  1  table write enable.
- cfg_addr  in  OPC_W  table entry address.
- cfg_data  in  1+LEN_W+CW_W  entry fields {legal, len, cw}.
- err_illegal  out  1  one-cycle pulse: an illegal opcode was consumed.

Behaviour:
- Reset (async assert, sync deassert by the system):
  - All table entries become {legal=0, len=0, cw=0}.
  - out_valid=0, out_cw=0, out_step=0, out_last=0, err_illegal=0; state IDLE.
- States:
  - IDLE: no op held.
  - ISSUE: an op is held in output registers; the table entry is copied at lookup.
- in_ready = !flush && (IDLE || (ISSUE && out_ready && out_last)). It is combinational from out_ready, for back-to-back ops with no bubble.
- Accept cycle T with entry legal=1: at T+1, out_valid=1, out_cw=entry.cw, out_step=0, out_last=(entry.len==0); state ISSUE. Latency is 1 cycle.
- Accept with entry legal=0:
  - No output beats.
  - err_illegal=1 at T+1 only.
  - State goes to or stays IDLE, unless the same cycle also completed a legal op's last beat; that beat still completes normally.
- ISSUE, out_valid && out_ready && !out_last: out_step increments; out_last=(out_step+1==len); out_cw unchanged.
- ISSUE, last beat handshaken: load a new op if one is accepted the same cycle (per the rules above), otherwise go to IDLE with out_valid=0.
- out_valid && !out_ready: out_cw, out_step and out_last hold stable. out_valid never drops without a handshake or flush.
- flush (highest priority):
  - Next cycle: out_valid=0, out_step=0, out_last=0, state IDLE.
  - in_ready is 0 while flush is high, so no opcode is consumed.
  - err_illegal is 0 next cycle.
- cfg_we:
  - Writes the entry at the clock edge, in any state.
  - A lookup of the same address in the same cycle returns the OLD entry.
  - An op already in ISSUE uses its latched copy and is unaffected by later writes.
- Widths: out_step wraps never; it stops at len ≤ 2^LEN_W−1. len uses the full LEN_W range.
- Outputs are registered, except in_ready.

Test Plan:
- Reset/default: rst_n low mid-ISSUE → out_valid=0 immediately, table cleared; then opcode 0x05 → no beats, err_illegal pulses 1 cycle after accept.
- Single-beat op: write addr 0x12 {1,0,0x2AAAAAA}; send 0x12 with out_ready=1 → next cycle out_valid=1, out_cw=0x2AAAAAA, out_step=0, out_last=1; following cycle out_valid=0.
- Multi-beat with stall: entry 0x40 {1,3,0x0000F0F}; out_ready pattern 1,0,0,1,1,1 → steps 0,1,1,1,2,3 seen, last only at step 3, out_cw constant.
- Back-to-back: 0x12 then 0x40 with in_valid held and out_ready=1 → in_ready high on the last beat, zero-bubble transition; 5 consecutive valid beats total.
- Write/lookup collision: cfg_we to 0x12 (cw=0x1) in the same cycle 0x12 is accepted → issues old cw 0x2AAAAAA; the next 0x12 issues 0x1.
- Flush: flush at step 1 of a 4-beat op while in_valid=1 → next cycle out_valid=0, the pending opcode is not consumed (in_ready=0), and the following op starts at step 0.
